// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
// Optional watchdog is enabled by defining RST_SEQ_WDT_EN.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        S_WAIT_LOCK,
        S_HOLD,
        S_STAGE,
        S_RUN
    } rst_state_t;

    typedef enum logic [1:0] {
        CAUSE_EXT,
        CAUSE_LOCK,
        CAUSE_SW,
        CAUSE_WDT
    } rst_cause_t;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Counter width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/rst_sync.sv
// Two-flop synchroniser with asynchronous active-low clear.
module rst_sync (
    input  logic i_clock,
    input  logic i_clear_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge i_clock or negedge i_clear_n) begin
        if (!i_clear_n) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/rst_sequencer.sv
// Ordered multi-channel reset sequencer with lock/software restart and cause latch.
// Define RST_SEQ_WDT_EN to add the watchdog restart source.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int unsigned NCH         = 3,
    parameter int unsigned HOLD_CYCLES = 64,
    parameter int unsigned STAGE_GAP   = 4,
    parameter int unsigned WDT_CYCLES  = 2**20
) (
    input  logic           i_clock,
    input  logic           i_reset_n,
    input  logic           i_lock,
    input  logic           i_sw_req,
    input  logic           i_wdt_kick,
    output logic [NCH-1:0] o_reset,
    output logic [NCH-1:0] o_reset_n,
    output logic           o_done,
    output logic [1:0]     o_cause
);

    localparam int unsigned CW = clog2_min1(max2(HOLD_CYCLES, STAGE_GAP));
    localparam int unsigned IW = $clog2(NCH) + 1;
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'(STAGE_GAP - 1);
    localparam logic [IW-1:0] LAST    = IW'(NCH - 1);
    localparam logic [NCH-1:0] ALL    = '1;

    logic w_rst_n_s;
    logic w_lock_s;
    logic w_wdt_fire;

    rst_state_t     r_state, w_state_nxt;
    rst_cause_t     r_cause, w_cause_nxt;
    logic [CW-1:0]  r_cnt, w_cnt_nxt;
    logic [IW-1:0]  r_idx, w_idx_nxt;
    logic [NCH-1:0] r_reset, w_reset_nxt;
    logic [NCH-1:0] r_reset_n;
    logic           r_done, w_done_nxt;

    rst_sync u_sync_rst (
        .i_clock  (i_clock),
        .i_clear_n(i_reset_n),
        .i_d      (1'b1),
        .o_q      (w_rst_n_s)
    );

    rst_sync u_sync_lock (
        .i_clock  (i_clock),
        .i_clear_n(i_reset_n),
        .i_d      (i_lock),
        .o_q      (w_lock_s)
    );

`ifdef RST_SEQ_WDT_EN
    localparam int unsigned WW = clog2_min1(WDT_CYCLES);
    localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 1);

    logic [WW-1:0] r_wdt;

    // A kick landing in the expiry cycle suppresses the restart.
    assign w_wdt_fire = (r_state == S_RUN) && (r_wdt == WDT_LAST) && !i_wdt_kick;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wdt <= '0;
        end else if (!w_rst_n_s || i_wdt_kick || r_reset[NCH-1] || w_wdt_fire) begin
            r_wdt <= '0;
        end else if (r_state == S_RUN) begin
            r_wdt <= r_wdt + WW'(1);
        end
    end
`else
    localparam int unsigned unused_wdt_cycles = WDT_CYCLES;
    logic w_unused_kick;
    assign w_unused_kick = i_wdt_kick;
    assign w_wdt_fire    = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = r_cause;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_reset_nxt = r_reset;
        w_done_nxt  = r_done;
        unique case (r_state)
            S_WAIT_LOCK: begin
                w_reset_nxt = ALL;
                w_done_nxt  = 1'b0;
                if (w_lock_s) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = HOLD_LD;
                end
            end
            S_HOLD: begin
                if (r_cnt == '0) begin
                    w_reset_nxt[0] = 1'b0;
                    if (NCH == 1) begin
                        w_state_nxt = S_RUN;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_STAGE;
                        w_cnt_nxt   = GAP_LD;
                        w_idx_nxt   = IW'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_STAGE: begin
                if (r_cnt == '0) begin
                    w_reset_nxt = r_reset & ~(NCH'(1) << r_idx);
                    if (r_idx == LAST) begin
                        w_state_nxt = S_RUN;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + IW'(1);
                        w_cnt_nxt = GAP_LD;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_RUN: begin
                w_done_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = S_WAIT_LOCK;
            end
        endcase
        // Restart priority: lock loss, then watchdog, then software.
        if (r_state != S_WAIT_LOCK) begin
            if (!w_lock_s) begin
                w_state_nxt = S_WAIT_LOCK;
                w_cause_nxt = CAUSE_LOCK;
                w_reset_nxt = ALL;
                w_done_nxt  = 1'b0;
            end else if (w_wdt_fire || i_sw_req) begin
                w_state_nxt = S_HOLD;
                w_cause_nxt = w_wdt_fire ? CAUSE_WDT : CAUSE_SW;
                w_cnt_nxt   = HOLD_LD;
                w_idx_nxt   = '0;
                w_reset_nxt = ALL;
                w_done_nxt  = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= S_WAIT_LOCK;
            r_cause   <= CAUSE_EXT;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_reset   <= ALL;
            r_reset_n <= '0;
            r_done    <= 1'b0;
        end else if (!w_rst_n_s) begin
            r_state   <= S_WAIT_LOCK;
            r_cause   <= CAUSE_EXT;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_reset   <= ALL;
            r_reset_n <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cause   <= w_cause_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_reset   <= w_reset_nxt;
            r_reset_n <= ~w_reset_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign o_reset   = r_reset;
    assign o_reset_n = r_reset_n;
    assign o_done    = r_done;
    assign o_cause   = r_cause;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer (NCH=3, HOLD=64, GAP=4, WDT=256).
// Watchdog scenarios are compiled in when RST_SEQ_WDT_EN is defined.
module tb_rst_sequencer;

    localparam int NCH  = 3;
    localparam int HOLD = 64;
    localparam int GAP  = 4;
    localparam int WDT  = 256;

    logic           clk    = 1'b0;
    logic           rst_n  = 1'b0;
    logic           lock   = 1'b1;
    logic           sw_req = 1'b0;
    logic           kick   = 1'b0;
    logic [NCH-1:0] o_reset;
    logic [NCH-1:0] o_reset_n;
    logic           o_done;
    logic [1:0]     o_cause;

    int n_cyc    = 0;
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) n_cyc <= n_cyc + 1;

    rst_sequencer #(
        .NCH        (NCH),
        .HOLD_CYCLES(HOLD),
        .STAGE_GAP  (GAP),
        .WDT_CYCLES (WDT)
    ) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .i_lock    (lock),
        .i_sw_req  (sw_req),
        .i_wdt_kick(kick),
        .o_reset   (o_reset),
        .o_reset_n (o_reset_n),
        .o_done    (o_done),
        .o_cause   (o_cause)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_rst(input logic [NCH-1:0] v, input int bound, output int at);
        at = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (o_reset === v) begin
                at = n_cyc;
                break;
            end
        end
    endtask

    task automatic wait_done(input logic v, input int bound, output int at);
        at = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (o_done === v) begin
                at = n_cyc;
                break;
            end
        end
    endtask

    // Channel k must fall at edge base + d + k*GAP.
    task automatic seq_check(input string tag, input int base, input int d, output int t_last);
        int t;
        wait_rst(3'b110, 300, t);
        check({tag, "_ch0_t"}, t - base, d);
        check({tag, "_ch0_n"}, o_reset_n, 3'b001);
        check({tag, "_ch0_done"}, o_done, 1'b0);
        wait_rst(3'b100, 20, t);
        check({tag, "_ch1_t"}, t - base, d + GAP);
        check({tag, "_ch1_done"}, o_done, 1'b0);
        wait_rst(3'b000, 20, t);
        check({tag, "_ch2_t"}, t - base, d + 2 * GAP);
        check({tag, "_ch2_done"}, o_done, 1'b1);
        check({tag, "_ch2_n"}, o_reset_n, 3'b111);
        t_last = t;
    endtask

    initial begin
        int base;
        int t;
        int t_end;

        // Reset state
        cycles(3);
        check("por_reset", o_reset, 3'b111);
        check("por_reset_n", o_reset_n, 3'b000);
        check("por_done", o_done, 1'b0);
        check("por_cause", o_cause, 2'd0);

        // 1: lock already high; 2 sync edges + 1 FSM edge + HOLD
        base  = n_cyc;
        rst_n = 1'b1;
        seq_check("c1", base, 3 + HOLD, t_end);
        check("c1_cause", o_cause, 2'd0);

        // 2: lock low for 500 cycles after release
        rst_n = 1'b0;
        cycles(2);
        lock  = 1'b0;
        rst_n = 1'b1;
        cycles(500);
        check("c2_held", o_reset, 3'b111);
        check("c2_done", o_done, 1'b0);
        base = n_cyc;
        lock = 1'b1;
        seq_check("c2", base, 3 + HOLD, t_end);

        // 3: software request in S_RUN
        cycles(5);
        base   = n_cyc;
        sw_req = 1'b1;
        @(negedge clk);
        sw_req = 1'b0;
        check("c3_reset", o_reset, 3'b111);
        check("c3_cause", o_cause, 2'd2);
        check("c3_done", o_done, 1'b0);
        seq_check("c3", base, 1 + HOLD, t_end);

        // 4: lock loss while ch1 released
        sw_req = 1'b1;
        @(negedge clk);
        sw_req = 1'b0;
        wait_rst(3'b100, 300, t);
        check("c4_reach", o_reset, 3'b100);
        lock = 1'b0;
        cycles(2);
        check("c4_sync", o_reset, 3'b100);
        cycles(1);
        check("c4_reset", o_reset, 3'b111);
        check("c4_cause", o_cause, 2'd1);
        check("c4_done", o_done, 1'b0);
        cycles(20);
        check("c4_wait", o_reset, 3'b111);
        sw_req = 1'b1;
        @(negedge clk);
        sw_req = 1'b0;
        cycles(2);
        check("c4_sw_ign", o_cause, 2'd1);
        check("c4_sw_rst", o_reset, 3'b111);
        base = n_cyc;
        lock = 1'b1;
        seq_check("c4", base, 3 + HOLD, t_end);

        // 5: simultaneous lock loss and software request
        cycles(3);
        lock = 1'b0;
        cycles(2);
        sw_req = 1'b1;
        @(negedge clk);
        sw_req = 1'b0;
        check("c5_prio_cause", o_cause, 2'd1);
        check("c5_prio_rst", o_reset, 3'b111);
        base = n_cyc;
        lock = 1'b1;
        wait_rst(3'b110, 300, t);
        check("c5_relock_t", t - base, 3 + HOLD);
        rst_n = 1'b0;
        #1;
        check("c5_async_rst", o_reset, 3'b111);
        check("c5_async_n", o_reset_n, 3'b000);
        check("c5_async_cause", o_cause, 2'd0);
        check("c5_async_done", o_done, 1'b0);
        @(negedge clk);
        base  = n_cyc;
        rst_n = 1'b1;
        seq_check("c5", base, 3 + HOLD, t_end);

`ifdef RST_SEQ_WDT_EN
        // 6: watchdog expiry, then periodic kicks
        wait_done(1'b0, WDT + 50, t);
        check("c6_fire_t", t - t_end, WDT);
        check("c6_cause", o_cause, 2'd3);
        check("c6_reset", o_reset, 3'b111);
        wait_done(1'b1, 300, t);
        check("c6_redone", o_done, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycles(199);
            kick = 1'b1;
            @(negedge clk);
            kick = 1'b0;
        end
        check("c6_kick_done", o_done, 1'b1);
        check("c6_kick_rst", o_reset, 3'b000);
        check("c6_kick_cause", o_cause, 2'd3);
`else
        // 6: no watchdog, S_RUN is stable
        cycles(600);
        check("c6_run_done", o_done, 1'b1);
        check("c6_run_rst", o_reset, 3'b000);
        check("c6_run_cause", o_cause, 2'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
